// File: rtl/ttl_serial_pkg.sv
// ============================================================================
// ttl_serial_pkg : state encodings and parity-polarity constants for the
//                  serial parity checker/generator pair.  Rev 1.0
// ============================================================================
`default_nettype none

package ttl_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_e;

   localparam logic c_parity_even = 1'b0;
   localparam logic c_parity_odd  = 1'b1;

   // Bit counter must be able to hold the value WIDTH itself.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ttl_serial_shift_parity.sv
// ============================================================================
// ttl_serial_shift_parity : positional shift register, XOR accumulator and
//                           bit counter for one serial frame.  Rev 1.0
// ============================================================================
`default_nettype none

module ttl_serial_shift_parity
   import ttl_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk_i,
   input  logic                          clear_i,
   input  logic                          load_i,
   input  logic                          shift_i,
   input  logic                          d_i,
   output logic [WIDTH-1:0]              shift_o,
   output logic                          acc_o,
   output logic [cnt_width(WIDTH)-1:0]   count_o
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic             acc_q,   acc_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      shift_d = shift_q;
      acc_d   = acc_q;
      count_d = count_q;
      if (load_i) begin
         shift_d    = '0;
         shift_d[0] = d_i;
         acc_d      = d_i;
         count_d    = CW'(1);
      end else if (shift_i && (count_q < CW'(WIDTH))) begin
         // Bit lands at the position given by the count, never past WIDTH.
         for (int i = 0; i < WIDTH; i++) begin
            if (count_q == CW'(i)) begin
               shift_d[i] = d_i;
            end
         end
         acc_d   = acc_q ^ d_i;
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         shift_q <= '0;
         acc_q   <= 1'b0;
         count_q <= '0;
      end else begin
         shift_q <= shift_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

   assign shift_o = shift_q;
   assign acc_o   = acc_q;
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ttl_serial_parity_checker.sv
// ============================================================================
// ttl_serial_parity_checker : receives WIDTH LSB-first data bits plus one
//                             parity bit and reports word and parity error.
//                             Rev 1.0
// ============================================================================
`default_nettype none

module ttl_serial_parity_checker
   import ttl_serial_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int ODD        = 0,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic             d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             valid_o,
   output logic             error_o,
   output logic             busy_o
);

   localparam int   CW    = cnt_width(WIDTH);
   localparam logic C_POL = (ODD != 0) ? c_parity_odd : c_parity_even;

   // Output delays are a simulation-only notion; outputs here follow the
   // registers directly, so only the parameter ranges are validated.
   if ((WIDTH < 2) || (WIDTH > 32) || (DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_param_check
      $error("ttl_serial_parity_checker: parameter out of range");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q,     q_d;
   logic             valid_q, valid_d;
   logic             error_q, error_d;
   logic             busy_q;

   logic             w_load;
   logic             w_shift;
   logic [WIDTH-1:0] w_shift_reg;
   logic             w_acc;
   logic [CW-1:0]    w_count;

   ttl_serial_shift_parity #(
      .WIDTH (WIDTH)
   ) u_shift_parity (
      .clk_i   (clk_i),
      .clear_i (clear_i),
      .load_i  (w_load),
      .shift_i (w_shift),
      .d_i     (d_i),
      .shift_o (w_shift_reg),
      .acc_o   (w_acc),
      .count_o (w_count)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      error_d = error_q;
      valid_d = 1'b0;
      w_load  = 1'b0;
      w_shift = 1'b0;
      // Start restarts from any state and silently drops a partial frame.
      if (enable_i && start_i) begin
         w_load  = 1'b1;
         state_d = ST_DATA;
      end else if (enable_i) begin
         case (state_q)
            ST_DATA: begin
               w_shift = 1'b1;
               if (w_count == CW'(WIDTH - 1)) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               q_d     = w_shift_reg;
               error_d = w_acc ^ d_i ^ C_POL;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         error_q <= error_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign q_o     = q_q;
   assign valid_o = valid_q;
   assign error_o = error_q;
   assign busy_o  = busy_q;

endmodule

`default_nettype wire
